// File: rtl/div_iter_param_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// Latency: none, wiring only.
// Backpressure: requester holds start_i until it has consumed ready_o.
interface div_iter_param_if #(
    parameter int WIDTH = 32
);
    logic               signed_i;
    logic               start_i;
    logic               annul_i;
    logic [WIDTH-1:0]   op_a_i;
    logic [WIDTH-1:0]   op_b_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               dbz_o;
    logic               busy_o;

    modport master (
        output signed_i, start_i, annul_i, op_a_i, op_b_i,
        input  result_o, ready_o, dbz_o, busy_o
    );

    modport slave (
        input  signed_i, start_i, annul_i, op_a_i, op_b_i,
        output result_o, ready_o, dbz_o, busy_o
    );
endinterface

// File: rtl/div_iter_param.sv
// Restoring divider producing {remainder, quotient}, signed or unsigned, one quotient bit per cycle.
// Latency: ready_o WIDTH+2 edges after start (2 for divide-by-zero); DIV_EARLY_OUT_EN trims it to WIDTH-lz+2.
// Backpressure: the result is held in DONE while start_i stays high; dropping start_i returns to IDLE.
module div_iter_param #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    div_iter_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_BUSY = 3'd1;
    localparam logic [2:0] S_FIX  = 3'd2;
    localparam logic [2:0] S_ZERO = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [2:0]         state_q,    state_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
    logic [WIDTH-1:0]   rem_q,      rem_d;
    logic [WIDTH-1:0]   quo_q,      quo_d;
    logic [WIDTH-1:0]   div_q,      div_d;
    logic               sign_a_q,   sign_a_d;
    logic               sign_b_q,   sign_b_d;
    logic               signed_q,   signed_d;
    logic               dbz_flag_q, dbz_flag_d;
    logic               ready_q,    ready_d;
    logic               dbz_q,      dbz_d;
    logic [2*WIDTH-1:0] result_q,   result_d;

    logic               op_a_neg;
    logic               op_b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign op_a_neg = bus.signed_i & bus.op_a_i[WIDTH-1];
    assign op_b_neg = bus.signed_i & bus.op_b_i[WIDTH-1];
    assign abs_a    = op_a_neg ? -bus.op_a_i : bus.op_a_i;
    assign abs_b    = op_b_neg ? -bus.op_b_i : bus.op_b_i;

    // rem_q < div_q always holds, so a set top bit of the shifted partial
    // remainder means the subtraction cannot borrow and its low bits fit.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;
    logic               borrow;

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = {1'b0, rem_shift[WIDTH-1:0]} - {1'b0, div_q};
    assign borrow    = trial[WIDTH] & ~rem_shift[WIDTH];

`ifdef DIV_EARLY_OUT_EN
    logic [CW-1:0] lz;

    always_comb begin
        lz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (abs_a[i]) begin
                lz = CW'(WIDTH - 1 - i);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        signed_d   = signed_q;
        dbz_flag_d = dbz_flag_q;
        ready_d    = 1'b0;
        dbz_d      = 1'b0;
        result_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    sign_a_d   = op_a_neg;
                    sign_b_d   = op_b_neg;
                    signed_d   = bus.signed_i;
                    dbz_flag_d = 1'b0;
                    rem_d      = '0;
                    div_d      = abs_b;
                    if (bus.op_b_i == '0) begin
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = S_ZERO;
                    end else begin
`ifdef DIV_EARLY_OUT_EN
                        // Leading zeros of the dividend would only shift in
                        // quotient zeros, so skip those iterations outright.
                        quo_d   = abs_a << lz;
                        cnt_d   = lz;
                        state_d = (abs_a == '0) ? S_FIX : S_BUSY;
`else
                        quo_d   = abs_a;
                        cnt_d   = '0;
                        state_d = S_BUSY;
`endif
                    end
                end
            end

            S_BUSY: begin
                if (bus.annul_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rem_d = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~borrow};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                // Remainder follows the dividend's sign; MIN/-1 wraps back to MIN.
                if (signed_q) begin
                    if (sign_a_q ^ sign_b_q) begin
                        quo_d = -quo_q;
                    end
                    if (sign_a_q) begin
                        rem_d = -rem_q;
                    end
                end
                state_d = S_DONE;
            end

            S_ZERO: begin
                quo_d      = '0;
                rem_d      = '0;
                dbz_flag_d = 1'b1;
                state_d    = S_DONE;
            end

            S_DONE: begin
                if (bus.start_i) begin
                    ready_d  = 1'b1;
                    dbz_d    = dbz_flag_q;
                    result_d = {rem_q, quo_q};
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            signed_q   <= 1'b0;
            dbz_flag_q <= 1'b0;
            ready_q    <= 1'b0;
            dbz_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            signed_q   <= signed_d;
            dbz_flag_q <= dbz_flag_d;
            ready_q    <= ready_d;
            dbz_q      <= dbz_d;
            result_q   <= result_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.dbz_o    = dbz_q;
    assign bus.busy_o   = (state_q != S_IDLE);
endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench for div_iter_param at WIDTH=32: expected results come from a
// behavioural / and % model and are popped when ready_o rises.
module tb_div_iter_param;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic clk = 1'b0;
    logic rst;

    div_iter_param_if #(.WIDTH(W)) bus ();

    div_iter_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] result;
        logic           dbz;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        exp_t e;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] abs_a;
        int lz;
        e.dbz = 1'b0;
        e.lat = W + 2;
        if (b == '0) begin
            q     = '0;
            r     = '0;
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
            if (sgn && a == MIN && b == '1) begin
                q = MIN;
                r = '0;
            end else if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            abs_a = (sgn && a[W-1]) ? -a : a;
            lz = W;
            for (int i = 0; i < W; i++) begin
                if (abs_a[i]) lz = W - 1 - i;
            end
`ifdef DIV_EARLY_OUT_EN
            e.lat = W - lz + 2;
`endif
        end
        e.result = {r, q};
        return e;
    endfunction

    // Full transaction: start, wait for ready, compare, hold, release.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input string name);
        exp_t e;
        int   cyc;
        logic seen;
        sb.push_back(model(a, b, sgn));
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.signed_i = sgn;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_e0: busy=%b ready=%b, expected busy=1 ready=0", name, bus.busy_o, bus.ready_o);
        end
        bus.op_a_i   = $urandom;
        bus.op_b_i   = $urandom;
        bus.signed_i = ~sgn;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            seen = (bus.ready_o === 1'b1);
        end
        e = sb.pop_front();
        checks++;
        if (!seen || cyc != e.lat) begin
            errors++;
            $display("FAIL %s_latency: seen=%b after %0d edges, expected %0d", name, seen, cyc, e.lat);
        end
        checks++;
        if (bus.result_o !== e.result) begin
            errors++;
            $display("FAIL %s_result: got %h expected %h", name, bus.result_o, e.result);
        end
        checks++;
        if (bus.dbz_o !== e.dbz) begin
            errors++;
            $display("FAIL %s_dbz: got %b expected %b", name, bus.dbz_o, e.dbz);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== e.result) begin
            errors++;
            $display("FAIL %s_hold: ready=%b result=%h, expected ready=1 result=%h", name, bus.ready_o, bus.result_o, e.result);
        end
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.dbz_o !== 1'b0 || bus.result_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: ready=%b dbz=%b busy=%b result=%h, expected all 0", name,
                     bus.ready_o, bus.dbz_o, bus.busy_o, bus.result_o);
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.annul_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.dbz_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b dbz=%b busy=%b result=%h, expected all 0",
                     bus.ready_o, bus.dbz_o, bus.busy_o, bus.result_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        do_op(32'd100, 32'd7, 1'b0, "u100_7");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_min_m1");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
        do_op(32'd0, 32'd9, 1'b0, "u0_9");
    endtask

    task automatic test_signed;
        do_op(-32'sd7, 32'd2, 1'b1, "s_m7_2");
        do_op(32'd7, -32'sd2, 1'b1, "s_7_m2");
        do_op(-32'sd7, -32'sd2, 1'b1, "s_m7_m2");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_overflow");
    endtask

    task automatic test_div_zero;
        exp_t e;
        sb.push_back(model(32'd5, 32'd0, 1'b0));
        bus.op_a_i   = 32'd5;
        bus.op_b_i   = 32'd0;
        bus.signed_i = 1'b0;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL dbz_early: ready=%b at E0+1, expected 0", bus.ready_o);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.dbz_o !== e.dbz || bus.result_o !== e.result) begin
            errors++;
            $display("FAIL dbz_result: ready=%b dbz=%b result=%h, expected ready=1 dbz=%b result=%h",
                     bus.ready_o, bus.dbz_o, bus.result_o, e.dbz, e.result);
        end
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.dbz_o !== 1'b1) begin
            errors++;
            $display("FAIL dbz_annul_ignored: ready=%b dbz=%b, expected 1 1", bus.ready_o, bus.dbz_o);
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.dbz_o !== 1'b0) begin
            errors++;
            $display("FAIL dbz_release: ready=%b dbz=%b, expected 0 0", bus.ready_o, bus.dbz_o);
        end
    endtask

    task automatic test_annul;
        logic rose;
        bus.op_a_i   = 32'd1000;
        bus.op_b_i   = 32'd3;
        bus.signed_i = 1'b0;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL annul_idle: busy=%b, expected 0", bus.busy_o);
        end
        bus.annul_i = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.ready_o !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL annul_no_ready: ready rose=%b, expected 0", rose);
        end
        do_op(32'd9, 32'd3, 1'b0, "after_annul");
    endtask

    task automatic test_rst_mid_busy;
        bus.op_a_i   = 32'd12345;
        bus.op_b_i   = 32'd17;
        bus.signed_i = 1'b0;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: busy=%b, expected 1", bus.busy_o);
        end
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.dbz_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== '0) begin
            errors++;
            $display("FAIL rst_mid_busy: ready=%b dbz=%b busy=%b result=%h, expected all 0",
                     bus.ready_o, bus.dbz_o, bus.busy_o, bus.result_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(32'd50, 32'd6, 1'b0, "after_rst");
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        for (int n = 0; n < 24; n++) begin
            a = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 500)) : W'($urandom);
            b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            if ($urandom_range(0, 1) == 1) b = -b;
            s = 1'($urandom_range(0, 1));
            do_op(a, b, s, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_rst_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
